regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined core. It is the successor to the fixed 32x32, 2R/1W register file.
- Adds configurable width and depth, NREAD read ports and two write ports with fixed priority.
- Adds optional write-through bypass and an optional hardwired-zero register.
- Adds a per-register pending scoreboard so the hazard unit can detect outstanding writers.
- Sits between decode (reads, issue marking) and writeback (writes).

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers. Power of two, at least 2. AW = $clog2(DEPTH).
- NREAD, 2, number of combinational read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 always reads 0, is never written and is never pending.
- BYPASS, 1, when 1 a same-cycle write is visible on the read ports (write-through).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- wea  in  1  write enable, port A.
- waa  in  AW  write address, port A.
- wda  in  WIDTH  write data, port A.
- web  in  1  write enable, port B.
- wab  in  AW  write address, port B.
- wdb  in  WIDTH  write data, port B.
- ra  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd  out  NREAD*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH].
- rbusy  out  NREAD  read port i targets a register whose pending bit is set.
- iss_en  in  1  mark register iss_addr pending (producer issued).
- iss_addr  in  AW  register to mark pending.
- flush  in  1  clear all pending bits (pipeline flush).
- pend_cnt  out  AW+1  number of pending registers.

Behaviour:
- Reset (reset==0, asynchronous): all registers cleared to 0, all pending bits cleared, pend_cnt=0. Consequently every rd reads 0 and every rbusy is 0 while reset is held and after release. Reset asserted mid-cycle aborts any write in progress.
- Writes:
  - Take effect on the rising clk edge.
  - Port A writes wda to waa when wea=1; port B writes wdb to wab when web=1.
  - Both ports enabled with the same address: port B data is stored.
  - When ZERO_REG=1, writes to address 0 are dropped.
- Reads:
  - Purely combinational; rd for port i = storage[ra_i], no latency.
  - ZERO_REG=1 and ra_i==0: rd_i=0 regardless of bypass.
  - BYPASS=1 and a write is enabled this cycle to ra_i: rd_i = that write's data, with B taking priority over A.
  - BYPASS=0: rd_i shows the old value until after the edge.
- Scoreboard (one pending bit per register), updated at the clk edge in this order:
  1. If flush=1, all bits are cleared.
  2. Otherwise, each enabled write clears the pending bit of its address.
  3. Then, if iss_en=1, pending[iss_addr] is set.
- Scoreboard priorities:
  - Issue wins over a same-cycle write or flush to the same address.
  - A write to a register that is not pending is legal and leaves pending unchanged.
  - Issue to an already-pending register leaves it pending; there is no nesting count.
  - ZERO_REG=1: issue to address 0 is ignored.
- rbusy_i = pending[ra_i] AND NOT (BYPASS=1 AND an enabled write targets ra_i this cycle). Forced to 0 for address 0 when ZERO_REG=1.
- pend_cnt:
  - Registered population count of the pending bits, updated on the same edge as the bits; equals popcount(pending) at all times.
  - Range is 0..DEPTH, so AW+1 bits are required with no wrap-around.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- No X propagation: storage is fully reset.

Test Plan:
- Reset: hold reset=0, apply random writes and issues, release -> every rd=0, rbusy=0, pend_cnt=0.
- Write/read with BYPASS=1: wea=1, waa=5, wda=32'hDEADBEEF and ra0=5 in the same cycle -> rd0=DEADBEEF combinationally, and still DEADBEEF on the next cycle with wea=0. With BYPASS=0, the same stimulus gives rd0=0 in the write cycle and DEADBEEF after the edge.
- Dual-write collision: waa=wab=7, wda=1, wdb=2, both enabled -> register 7 reads 2. Write to address 0 with ZERO_REG=1 -> rd=0.
- Scoreboard sequence:
  - issue 3, then issue 9 -> pend_cnt=2, and rbusy0=1 with ra0=3.
  - Write to 3 -> rbusy0=0 in the write cycle (bypass); pend_cnt=1 after the edge.
  - Issue 9 and write 9 in the same cycle -> 9 stays pending, pend_cnt=1.
- Flush: pending {2,4,6}, assert flush with iss_en=1, iss_addr=4 -> only 4 pending, pend_cnt=1.
- Saturation: DEPTH=8, ZERO_REG=0, issue all 8 registers -> pend_cnt=8 (4'b1000). Async reset asserted mid-cycle -> pend_cnt=0 immediately.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NREAD combinational read ports, two
// prioritised write ports, optional write-through bypass and hardwired zero,
// plus a per-register pending scoreboard with a registered population count.
module regfile_mp #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wea,
    input  logic [AW-1:0]          waa,
    input  logic [WIDTH-1:0]       wda,
    input  logic                   web,
    input  logic [AW-1:0]          wab,
    input  logic [WIDTH-1:0]       wdb,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rbusy,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [AW:0]            pend_cnt
);

    localparam bit HAS_ZERO   = (ZERO_REG != 0);
    localparam bit BYPASS_ON  = (BYPASS != 0);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic [CW-1:0]    cnt_next;

    logic wa_ok;
    logic wb_ok;
    logic iss_ok;

    // Effective enables: register 0 is untouchable when hardwired, and a held
    // reset suppresses writes so the bypass path also reads zero.
    assign wa_ok  = reset && wea && !(HAS_ZERO && (waa == AW'(0)));
    assign wb_ok  = reset && web && !(HAS_ZERO && (wab == AW'(0)));
    assign iss_ok = iss_en && !(HAS_ZERO && (iss_addr == AW'(0)));

    // Storage; port B is assigned last so it wins an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (wa_ok) begin
                mem[waa] <= wda;
            end
            if (wb_ok) begin
                mem[wab] <= wdb;
            end
        end
    end

    // Scoreboard next state: flush, else write-clears, then issue sets.
    always_comb begin
        pend_next = pend;
        if (flush) begin
            pend_next = '0;
        end else begin
            if (wea) begin
                pend_next[waa] = 1'b0;
            end
            if (web) begin
                pend_next[wab] = 1'b0;
            end
        end
        if (iss_ok) begin
            pend_next[iss_addr] = 1'b1;
        end
        if (HAS_ZERO) begin
            pend_next[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            cnt_next = cnt_next + CW'(pend_next[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    // Read ports with optional write-through; B data beats A data.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             byp_a;
        logic             byp_b;
        logic [WIDTH-1:0] data;
        logic             busy;

        assign addr  = ra[i*AW +: AW];
        assign byp_a = BYPASS_ON && wa_ok && (waa == addr);
        assign byp_b = BYPASS_ON && wb_ok && (wab == addr);

        always_comb begin
            data = mem[addr];
            busy = pend[addr];
            if (byp_b) begin
                data = wdb;
                busy = 1'b0;
            end else if (byp_a) begin
                data = wda;
                busy = 1'b0;
            end
            if (HAS_ZERO && (addr == AW'(0))) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = data;
        assign rbusy[i]             = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default, no-bypass and small saturating
// configurations driven from a vector table plus hand-written sequences.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        wea, web, iss_en, flush;
    logic [4:0]  waa, wab, iss_addr;
    logic [31:0] wda, wdb;
    logic [9:0]  ra;
    logic [63:0] rd, nb_rd;
    logic [1:0]  rbusy, nb_rbusy;
    logic [5:0]  pend_cnt, nb_pend_cnt;

    logic        s_wea, s_web, s_iss_en, s_flush;
    logic [2:0]  s_waa, s_wab, s_iss_addr, s_ra;
    logic [31:0] s_wda, s_wdb, s_rd;
    logic [0:0]  s_rbusy;
    logic [3:0]  s_pend_cnt;

    int errors = 0;
    int checks = 0;

    regfile_mp u_dut (
        .clk(clk), .reset(reset),
        .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
        .ra(ra), .rd(rd), .rbusy(rbusy),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset),
        .wea(wea), .waa(waa), .wda(wda), .web(web), .wab(wab), .wdb(wdb),
        .ra(ra), .rd(nb_rd), .rbusy(nb_rbusy),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_cnt(nb_pend_cnt)
    );

    regfile_mp #(.DEPTH(8), .NREAD(1), .ZERO_REG(0)) u_sat (
        .clk(clk), .reset(reset),
        .wea(s_wea), .waa(s_waa), .wda(s_wda), .web(s_web), .wab(s_wab), .wdb(s_wdb),
        .ra(s_ra), .rd(s_rd), .rbusy(s_rbusy),
        .iss_en(s_iss_en), .iss_addr(s_iss_addr), .flush(s_flush), .pend_cnt(s_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wea;
        logic [4:0]  waa;
        logic [31:0] wda;
        logic        web;
        logic [4:0]  wab;
        logic [31:0] wdb;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iss;
        logic [4:0]  ia;
        logic        flush;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;
        logic [5:0]  e_cnt;
        logic        chk_nb;
        logic [31:0] e_nb;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wea = 0; web = 0; iss_en = 0; flush = 0;
        waa = 0; wab = 0; wda = 0; wdb = 0; iss_addr = 0; ra = 0;
        s_wea = 0; s_web = 0; s_iss_en = 0; s_flush = 0;
        s_waa = 0; s_wab = 0; s_wda = 0; s_wdb = 0; s_iss_addr = 0; s_ra = 0;
    endtask

    initial begin
        //        wea waa wda           web wab wdb    ra0 ra1 iss ia fl  rd0           rd1           busy  cnt nb nb_rd0
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     5,  0,  0, 0, 0, 32'hDEADBEEF, 0,            2'b00, 0, 1, 0};
        tbl[1]  = '{0, 0, 0,            0, 0, 0,     5,  1,  0, 0, 0, 32'hDEADBEEF, 0,            2'b00, 0, 1, 32'hDEADBEEF};
        tbl[2]  = '{1, 7, 1,            1, 7, 2,     7,  5,  0, 0, 0, 2,            32'hDEADBEEF, 2'b00, 0, 1, 0};
        tbl[3]  = '{1, 0, 32'hFFFF,     0, 0, 0,     0,  7,  0, 0, 0, 0,            2,            2'b00, 0, 1, 0};
        tbl[4]  = '{0, 0, 0,            0, 0, 0,     0,  7,  0, 0, 0, 0,            2,            2'b00, 0, 1, 0};
        tbl[5]  = '{0, 0, 0,            0, 0, 0,     3,  9,  1, 3, 0, 0,            0,            2'b00, 1, 0, 0};
        tbl[6]  = '{0, 0, 0,            0, 0, 0,     3,  9,  1, 9, 0, 0,            0,            2'b01, 2, 0, 0};
        tbl[7]  = '{0, 0, 0,            0, 0, 0,     3,  9,  0, 0, 0, 0,            0,            2'b11, 2, 0, 0};
        tbl[8]  = '{1, 3, 33,           0, 0, 0,     3,  9,  0, 0, 0, 33,           0,            2'b10, 1, 0, 0};
        tbl[9]  = '{0, 0, 0,            1, 9, 99,    9,  3,  1, 9, 0, 99,           33,           2'b00, 1, 0, 0};
        tbl[10] = '{0, 0, 0,            0, 0, 0,     9,  3,  0, 0, 0, 99,           33,           2'b01, 1, 0, 0};
        tbl[11] = '{0, 0, 0,            0, 0, 0,     0,  9,  1, 0, 0, 0,            99,           2'b10, 1, 0, 0};
        tbl[12] = '{0, 0, 0,            0, 0, 0,     0,  9,  0, 0, 0, 0,            99,           2'b10, 1, 0, 0};
        tbl[13] = '{0, 0, 0,            0, 0, 0,     9,  9,  0, 0, 1, 99,           99,           2'b11, 0, 0, 0};
        tbl[14] = '{0, 0, 0,            0, 0, 0,     2,  4,  1, 2, 0, 0,            0,            2'b00, 1, 0, 0};
        tbl[15] = '{0, 0, 0,            0, 0, 0,     2,  4,  1, 4, 0, 0,            0,            2'b01, 2, 0, 0};
        tbl[16] = '{0, 0, 0,            0, 0, 0,     2,  4,  1, 6, 0, 0,            0,            2'b11, 3, 0, 0};
        tbl[17] = '{0, 0, 0,            0, 0, 0,     2,  4,  1, 4, 1, 0,            0,            2'b11, 1, 0, 0};
        tbl[18] = '{0, 0, 0,            0, 0, 0,     2,  4,  0, 0, 0, 0,            0,            2'b10, 1, 0, 0};

        // Reset held while writes and issues are presented.
        idle();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            wea = 1; waa = 5'(c + 1); wda = 32'hA5A5_0000 + 32'(c);
            web = 1; wab = 5'(c + 10); wdb = 32'h5A5A_0000 + 32'(c);
            iss_en = 1; iss_addr = 5'(c + 1);
            ra = {5'(c + 10), 5'(c + 1)};
            #1;
            chk("rst_rd", rd, 64'h0);
            chk("rst_rbusy", 64'(rbusy), 64'h0);
        end
        chk("rst_cnt", 64'(pend_cnt), 64'h0);
        @(negedge clk);
        idle();
        reset = 1'b1;
        ra = {5'd10, 5'd1};
        @(posedge clk); #1;
        chk("post_rst_rd", rd, 64'h0);
        chk("post_rst_rbusy", 64'(rbusy), 64'h0);
        chk("post_rst_cnt", 64'(pend_cnt), 64'h0);
        chk("post_rst_sat_cnt", 64'(s_pend_cnt), 64'h0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            wea = tbl[i].wea; waa = tbl[i].waa; wda = tbl[i].wda;
            web = tbl[i].web; wab = tbl[i].wab; wdb = tbl[i].wdb;
            ra = {tbl[i].ra1, tbl[i].ra0};
            iss_en = tbl[i].iss; iss_addr = tbl[i].ia; flush = tbl[i].flush;
            #1;
            chk($sformatf("v%0d_rd0", i), 64'(rd[31:0]), 64'(tbl[i].e_rd0));
            chk($sformatf("v%0d_rd1", i), 64'(rd[63:32]), 64'(tbl[i].e_rd1));
            chk($sformatf("v%0d_rbusy", i), 64'(rbusy), 64'(tbl[i].e_busy));
            if (tbl[i].chk_nb) begin
                chk($sformatf("v%0d_nobyp_rd0", i), 64'(nb_rd[31:0]), 64'(tbl[i].e_nb));
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_cnt", i), 64'(pend_cnt), 64'(tbl[i].e_cnt));
        end
        @(negedge clk);
        idle();

        // Saturation: every register of an 8-deep file pending.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_iss_en = 1; s_iss_addr = 3'(k);
        end
        @(negedge clk);
        s_iss_en = 0; s_ra = 3'd0;
        #1;
        chk("sat_cnt", 64'(s_pend_cnt), 64'd8);
        chk("sat_rbusy_r0", 64'(s_rbusy), 64'd1);

        // Mid-cycle asynchronous reset clears state immediately.
        ra = {5'd7, 5'd5};
        #1;
        chk("pre_async_rd", rd, {32'd2, 32'hDEADBEEF});
        #1;
        reset = 1'b0;
        #1;
        chk("async_sat_cnt", 64'(s_pend_cnt), 64'd0);
        chk("async_sat_rbusy", 64'(s_rbusy), 64'd0);
        chk("async_cnt", 64'(pend_cnt), 64'd0);
        chk("async_rd", rd, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
